// File: rtl/turbo_pkg.sv
// Shared constants, FSM encoding and the RSC (1, 5/7) trellis step for the turbo encoder.
// The decoder trellis tables are derived from rsc_step as well.
package turbo_pkg;

   localparam int unsigned K       = 5;
   localparam int unsigned N       = K + 2;
   localparam int unsigned SOFT_W  = 4;
   localparam int unsigned PLANE_W = $clog2(SOFT_W);
   localparam int unsigned CNT_W   = 3;
   localparam int unsigned BUS_W   = 3 * N;

   // Interleaver: u'[k] = u[PI[k]]
   localparam logic [K-1:0][CNT_W-1:0] PI = {3'd3, 3'd1, 3'd2, 3'd4, 3'd0};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ENCODE = 2'd1,
      EMIT   = 2'd2
   } state_e;

   typedef struct packed {
      logic [N-1:0] sys;
      logic [N-1:0] par1;
      logic [N-1:0] par2;
   } cw_t;

   typedef struct packed {
      logic       p;
      logic [1:0] next;
   } rsc_out_t;

   // State is {s1, s2}; feedback a = u^s1^s2, parity p = a^s2, next state {a, s1}.
   function automatic rsc_out_t rsc_step(input logic u, input logic [1:0] st);
      rsc_out_t r;
      logic     a;
      a      = u ^ st[1] ^ st[0];
      r.p    = a ^ st[0];
      r.next = {a, st[1]};
      return r;
   endfunction

endpackage

// File: rtl/turbo_encoder_tx_if.sv
// Request/frame bus between a message source, turbo_encoder_tx and the decoder input.
interface turbo_encoder_tx_if;
   import turbo_pkg::*;

   logic [K-1:0]     data_i;
   logic             start_i;
   logic [BUS_W-1:0] data_o;
   logic             start_o;
   logic             busy_o;
   logic             done_o;

   modport master (
      output data_i, start_i,
      input  data_o, start_o, busy_o, done_o
   );

   modport slave (
      input  data_i, start_i,
      output data_o, start_o, busy_o, done_o
   );

endinterface

// File: rtl/turbo_encoder_tx_rsc_enc.sv
// One clocked RSC constituent encoder; parity p is combinational on the current state and u.
module rsc_enc
   import turbo_pkg::*;
(
   input  logic clk_p_i,
   input  logic reset_p_i,
   input  logic clear,
   input  logic en,
   input  logic u,
   output logic p
);

   logic [1:0] st_q;
   rsc_out_t   step_c;

   assign step_c = rsc_step(u, st_q);
   assign p      = step_c.p;

   always_ff @(posedge clk_p_i or posedge reset_p_i) begin
      if (reset_p_i)  st_q <= '0;
      else if (clear) st_q <= '0;
      else if (en)    st_q <= step_c.next;
   end

endmodule

// File: rtl/turbo_encoder_tx.sv
// Rate-1/3 turbo encoder: encodes a K-bit message over N trellis steps, then serializes the
// soft-mapped codewords as SOFT_W bit-plane beats plus one trailing zero beat.
module turbo_encoder_tx
   import turbo_pkg::*;
#(
   parameter logic signed [SOFT_W-1:0] AMP = 4'sd3
) (
   input  logic              clk_p_i,
   input  logic              reset_p_i,
   turbo_encoder_tx_if.slave bus
);

   localparam logic [SOFT_W-1:0] SOFT_ONE  = AMP;
   localparam logic [SOFT_W-1:0] SOFT_ZERO = SOFT_W'(-AMP);

   if ((int'(AMP) < 1) || (int'(AMP) > (2 ** (SOFT_W - 1)) - 1)) begin : g_amp_range
      $error("turbo_encoder_tx: AMP out of range 1..2^(SOFT_W-1)-1");
   end

   state_e           state_q, state_n;
   logic [CNT_W-1:0] step_q, step_n;
   logic [CNT_W-1:0] beat_q, beat_n;
   logic [K-1:0]     msg_q, msg_n;
   cw_t              cw_q, cw_n;

   logic             u_c, ui_c, p1_c, p2_c;
   logic             rsc_clear_c, rsc_en_c;

   logic [BUS_W-1:0] data_q, data_n;
   logic             start_q, start_n;
   logic             busy_q, busy_n;
   logic             done_q, done_n;

   // Bit plane b of every mapped symbol: code bit selects the +AMP or -AMP pattern.
   function automatic logic [BUS_W-1:0] soft_plane(input cw_t cw, input logic [PLANE_W-1:0] b);
      logic [BUS_W-1:0] v;
      v = cw;
      return ({BUS_W{SOFT_ONE[b]}} & v) | ({BUS_W{SOFT_ZERO[b]}} & ~v);
   endfunction

   rsc_enc u_rsc1 (
      .clk_p_i   (clk_p_i),
      .reset_p_i (reset_p_i),
      .clear     (rsc_clear_c),
      .en        (rsc_en_c),
      .u         (u_c),
      .p         (p1_c)
   );

   rsc_enc u_rsc2 (
      .clk_p_i   (clk_p_i),
      .reset_p_i (reset_p_i),
      .clear     (rsc_clear_c),
      .en        (rsc_en_c),
      .u         (ui_c),
      .p         (p2_c)
   );

   always_ff @(posedge clk_p_i or posedge reset_p_i) begin
      if (reset_p_i) begin
         state_q <= IDLE;
         step_q  <= '0;
         beat_q  <= '0;
         msg_q   <= '0;
         cw_q    <= '0;
         data_q  <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         step_q  <= step_n;
         beat_q  <= beat_n;
         msg_q   <= msg_n;
         cw_q    <= cw_n;
         data_q  <= data_n;
         start_q <= start_n;
         busy_q  <= busy_n;
         done_q  <= done_n;
      end
   end

   always_comb begin
      state_n     = state_q;
      step_n      = step_q;
      beat_n      = beat_q;
      msg_n       = msg_q;
      cw_n        = cw_q;
      rsc_clear_c = 1'b0;
      rsc_en_c    = 1'b0;
      u_c         = 1'b0;
      ui_c        = 1'b0;

      // Tail steps feed literal zeros into both encoders.
      if (step_q < CNT_W'(K)) begin
         u_c  = msg_q[CNT_W'(K - 1) - step_q];
         ui_c = msg_q[CNT_W'(K - 1) - PI[step_q]];
      end

      unique case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               state_n     = ENCODE;
               msg_n       = bus.data_i;
               step_n      = '0;
               cw_n        = '0;
               rsc_clear_c = 1'b1;
            end
         end
         ENCODE: begin
            rsc_en_c                             = 1'b1;
            cw_n.sys[CNT_W'(N - 1) - step_q]  = u_c;
            cw_n.par1[CNT_W'(N - 1) - step_q] = p1_c;
            cw_n.par2[CNT_W'(N - 1) - step_q] = p2_c;
            if (step_q == CNT_W'(N - 1)) begin
               state_n = EMIT;
               beat_n  = '0;
            end else begin
               step_n = step_q + CNT_W'(1);
            end
         end
         EMIT: begin
            if (beat_q == CNT_W'(SOFT_W)) state_n = IDLE;
            else                          beat_n  = beat_q + CNT_W'(1);
         end
         default: state_n = IDLE;
      endcase

      // Outputs are registered from the next state so they line up with the frame cycles.
      busy_n  = (state_n != IDLE);
      start_n = (state_n == EMIT);
      done_n  = (state_n == EMIT) && (beat_n == CNT_W'(SOFT_W));
      data_n  = '0;
      if ((state_n == EMIT) && (beat_n < CNT_W'(SOFT_W)))
         data_n = soft_plane(cw_n, beat_n[PLANE_W-1:0]);
   end

   assign bus.data_o  = data_q;
   assign bus.start_o = start_q;
   assign bus.busy_o  = busy_q;
   assign bus.done_o  = done_q;

endmodule

// File: tb/tb_turbo_encoder_tx.sv
// Directed bench for turbo_encoder_tx: hand-computed codewords and bit-plane beats under AMP=3.
module tb_turbo_encoder_tx;

   logic clk_p_i   = 1'b0;
   logic reset_p_i = 1'b1;

   turbo_encoder_tx_if bus ();

   turbo_encoder_tx #(.AMP(4'sd3)) dut (
      .clk_p_i   (clk_p_i),
      .reset_p_i (reset_p_i),
      .bus       (bus)
   );

   always #5 clk_p_i = ~clk_p_i;

   int checks   = 0;
   int failures = 0;

   // sys=1011000, par1=1100101, par2=1101100 for message 10110
   localparam logic [20:0] CW_A = {7'b1011000, 7'b1100101, 7'b1101100};

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Called at a negedge; start is accepted at the next posedge (cycle 0).
   // Returns early at the negedge of beat abort_beat when abort_beat >= 0.
   task automatic run_block(input string tag, input logic [4:0] m, input logic [20:0] cw,
                            input int abort_beat);
      logic [20:0] beat_exp [5];
      beat_exp[0] = 21'h1FFFFF;
      beat_exp[1] = cw;
      beat_exp[2] = ~cw;
      beat_exp[3] = ~cw;
      beat_exp[4] = '0;
      bus.data_i  = m;
      bus.start_i = 1'b1;
      @(negedge clk_p_i);
      bus.start_i = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         if (i < 8) begin
            if (i == 1 || i == 7) begin
               check($sformatf("%s_enc%0d_busy", tag, i), 32'(bus.busy_o), 32'd1);
               check($sformatf("%s_enc%0d_start_o", tag, i), 32'(bus.start_o), 32'd0);
            end
         end else begin
            check($sformatf("%s_beat%0d_data", tag, i - 8), 32'(bus.data_o), 32'(beat_exp[i-8]));
            check($sformatf("%s_beat%0d_start_o", tag, i - 8), 32'(bus.start_o), 32'd1);
            check($sformatf("%s_beat%0d_done", tag, i - 8), 32'(bus.done_o), 32'(i == 12));
            if (i - 8 == abort_beat) return;
         end
         @(negedge clk_p_i);
      end
      check($sformatf("%s_idle_busy", tag), 32'(bus.busy_o), 32'd0);
      check($sformatf("%s_idle_start_o", tag), 32'(bus.start_o), 32'd0);
   endtask

   initial begin
      int prev_start;
      int rise_cnt;
      int rise_at [3];
      int extra;

      bus.data_i  = '0;
      bus.start_i = 1'b0;

      // Reset state
      @(negedge clk_p_i);
      check("rst_data_o", 32'(bus.data_o), 32'd0);
      check("rst_start_o", 32'(bus.start_o), 32'd0);
      check("rst_busy_o", 32'(bus.busy_o), 32'd0);
      check("rst_done_o", 32'(bus.done_o), 32'd0);
      reset_p_i = 1'b0;
      @(negedge clk_p_i);

      run_block("msg10110", 5'b10110, CW_A, -1);
      run_block("msg00000", 5'b00000, 21'h0, -1);

      // Start pulses during ENCODE and EMIT are ignored and not queued
      bus.data_i  = 5'b00000;
      bus.start_i = 1'b1;
      @(negedge clk_p_i);
      for (int c = 1; c <= 12; c++) begin
         bus.start_i = (c == 3 || c == 10 || c == 12);
         bus.data_i  = 5'b11111;
         if (c == 8)  check("ign_beat0", 32'(bus.data_o), 32'h1FFFFF);
         if (c == 9)  check("ign_beat1", 32'(bus.data_o), 32'h0);
         if (c == 12) check("ign_done", 32'(bus.done_o), 32'd1);
         @(negedge clk_p_i);
      end
      bus.start_i = 1'b0;
      extra = 0;
      for (int c = 0; c < 14; c++) begin
         if (bus.start_o || bus.busy_o) extra++;
         @(negedge clk_p_i);
      end
      check("ign_no_queued_frame", 32'(extra), 32'd0);

      // start_i held high: a frame every 13 cycles
      bus.data_i  = 5'b10110;
      bus.start_i = 1'b1;
      prev_start  = 0;
      rise_cnt    = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk_p_i);
         if (bus.start_o && prev_start == 0) begin
            if (rise_cnt < 3) rise_at[rise_cnt] = c;
            rise_cnt++;
         end
         prev_start = int'(bus.start_o);
      end
      check("held_rise_count", 32'(rise_cnt), 32'd3);
      check("held_first_frame", 32'(rise_at[0]), 32'd8);
      check("held_period_1", 32'(rise_at[1] - rise_at[0]), 32'd13);
      check("held_period_2", 32'(rise_at[2] - rise_at[1]), 32'd13);
      bus.start_i = 1'b0;
      for (int c = 0; c < 20 && bus.busy_o; c++) @(negedge clk_p_i);
      check("held_drain_idle", 32'(bus.busy_o), 32'd0);
      @(negedge clk_p_i);

      // Reset during EMIT beat 2 clears outputs asynchronously
      run_block("abort", 5'b10110, CW_A, 2);
      reset_p_i = 1'b1;
      #1;
      check("abort_data_o", 32'(bus.data_o), 32'd0);
      check("abort_start_o", 32'(bus.start_o), 32'd0);
      check("abort_busy_o", 32'(bus.busy_o), 32'd0);
      check("abort_done_o", 32'(bus.done_o), 32'd0);
      @(negedge clk_p_i);
      reset_p_i = 1'b0;
      extra = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk_p_i);
         if (bus.start_o || bus.busy_o || bus.data_o != '0) extra++;
      end
      check("abort_no_partial", 32'(extra), 32'd0);
      run_block("post_rst", 5'b10110, CW_A, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
